// File: rtl/tick_period_monitor.sv
// rtl/tick_period_monitor.sv - interval checker for a periodic one-cycle strobe
// Optional saturating error counter: define TICK_PERIOD_MONITOR_ERRCNT_EN.
module tick_period_monitor #(
    parameter int counterbits = 16,
    parameter int wholeway    = 26214,
    parameter int tolerance   = 2,
    parameter int lockcount   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    output logic [counterbits-1:0] period_out,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   err_early,
    output logic                   err_missing,
    output logic [7:0]             err_count
);

    localparam logic [counterbits-1:0] lo      = counterbits'(wholeway - tolerance);
    localparam logic [counterbits-1:0] hi      = counterbits'(wholeway + tolerance);
    localparam logic [counterbits-1:0] cnt_one = counterbits'(1);
    localparam logic [3:0]             lock_target = 4'(lockcount);

    typedef enum logic [1:0] {HUNT = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    state_t                 state, state_next;
    logic                   tick_d;
    logic [counterbits-1:0] cnt;
    logic [3:0]             good, good_next;
    logic                   rise, is_early, in_window, timeout;
    logic                   capture, early_evt, missing_evt;

    assign rise      = tick & ~tick_d;
    assign is_early  = cnt < lo;
    assign in_window = !is_early && (cnt <= hi);
    // A rise landing on the timeout cycle wins and is judged with cnt == hi.
    assign timeout   = !rise && (cnt == hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: if (rise) state_next = ACQUIRE;
            ACQUIRE: begin
                if (rise) begin
                    if (in_window && (good + 4'd1 == lock_target)) state_next = LOCKED;
                end else if (timeout) begin
                    state_next = HUNT;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (is_early) state_next = ACQUIRE;
                end else if (timeout) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        early_evt   = 1'b0;
        missing_evt = 1'b0;
        good_next   = good;
        case (state)
            ACQUIRE: begin
                if (rise) begin
                    capture = 1'b1;
                    if (in_window && (good + 4'd1 != lock_target)) begin
                        good_next = good + 4'd1;
                    end else begin
                        early_evt = is_early;
                        good_next = 4'd0;
                    end
                end else if (timeout) begin
                    missing_evt = 1'b1;
                    good_next   = 4'd0;
                end
            end
            LOCKED: begin
                good_next = 4'd0;
                if (rise) begin
                    capture   = 1'b1;
                    early_evt = is_early;
                end else if (timeout) begin
                    missing_evt = 1'b1;
                end
            end
            default: good_next = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d       <= 1'b0;
            cnt          <= '0;
            good         <= 4'd0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_early    <= 1'b0;
            err_missing  <= 1'b0;
        end else begin
            tick_d <= tick;
            good   <= good_next;
            // cnt is held at 0 while hunting so a dead strobe raises one error only.
            if (rise)                              cnt <= cnt_one;
            else if (state == HUNT || missing_evt) cnt <= '0;
            else if (cnt != '1)                    cnt <= cnt + cnt_one;
            if (capture) period_out <= cnt;
            period_valid <= capture;
            locked       <= (state == LOCKED);
            err_early    <= early_evt;
            err_missing  <= missing_evt;
        end
    end

`ifdef TICK_PERIOD_MONITOR_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                            err_cnt <= 8'd0;
        else if ((early_evt || missing_evt) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign err_count = err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// tb/tb_tick_period_monitor.sv - scoreboard bench for tick_period_monitor
module tb_tick_period_monitor;

    localparam int CB  = 8;
    localparam int WW  = 10;
    localparam int TOL = 1;
    localparam int LC  = 3;
    localparam int LO  = WW - TOL;
    localparam int HI  = WW + TOL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic [CB-1:0] period_out;
    logic          period_valid, locked, err_early, err_missing;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    tick_period_monitor #(
        .counterbits(CB), .wholeway(WW), .tolerance(TOL), .lockcount(LC)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .period_out(period_out), .period_valid(period_valid), .locked(locked),
        .err_early(err_early), .err_missing(err_missing), .err_count(err_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int kind; int val;} ev_t;
    ev_t expq[$];
    int  exp_locked[int];
    int  exp_ec[int];
    int  checks = 0;
    int  errors = 0;

    // Reference model: interval arithmetic on rise times, no counter register.
    int mode = 0;          // 0 hunting, 1 acquiring, 2 locked
    int last_rise = 0;
    int run = 0;
    int errs = 0;
    bit prev_tick = 1'b0;

    function automatic void push_ev(int c, int k, int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        expq.push_back(e);
    endfunction

    task automatic model_step(bit t);
        int c = cyc;
        int since = c - last_rise;
        bit r = t && !prev_tick;
        prev_tick = t;
        if (r) begin
            if (mode == 0) begin
                mode = 1; run = 0;
            end else begin
                push_ev(c + 1, 0, since);
                if (since < LO) begin
                    push_ev(c + 1, 1, 0);
                    errs++; run = 0; mode = 1;
                end else if (mode == 1) begin
                    run++;
                    if (run == LC) begin mode = 2; run = 0; end
                end
            end
            last_rise = c;
        end else if (mode != 0 && since == HI) begin
            push_ev(c + 1, 2, 0);
            errs++; mode = 0;
        end
        exp_locked[c + 2] = (mode == 2) ? 1 : 0;
`ifdef TICK_PERIOD_MONITOR_ERRCNT_EN
        exp_ec[c + 1] = (errs > 255) ? 255 : errs;
`else
        exp_ec[c + 1] = 0;
`endif
    endtask

    task automatic drive_cycle(bit t);
        @(posedge clk); #1;
        tick = t;
        model_step(t);
    endtask

    task automatic tick_seq(int gap, int width);
        for (int i = 0; i < gap; i++) drive_cycle(i < width);
    endtask

    task automatic release_reset();
        tick = 1'b0; reset = 1'b0;
        exp_locked[cyc] = 0; exp_locked[cyc + 1] = 0;
        exp_ec[cyc] = 0;
        model_step(1'b0);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(bit t);
        @(posedge clk); #1;
        tick = t; reset = 1'b1;
        expq.delete();
        mode = 0; run = 0; errs = 0; prev_tick = 1'b0;
        exp_locked[cyc] = 0; exp_locked[cyc + 1] = 0; exp_locked[cyc + 2] = 0;
        exp_ec[cyc] = 0; exp_ec[cyc + 1] = 0;
        @(negedge clk);
        chk("rst_period_valid", int'(period_valid), 0);
        chk("rst_period_out", int'(period_out), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_early", int'(err_early), 0);
        chk("rst_err_missing", int'(err_missing), 0);
        chk("rst_err_count", int'(err_count), 0);
        @(posedge clk); #1;
        release_reset();
    endtask

    task automatic take(bit present, int kind, int val);
        ev_t e;
        if (!present) return;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, expected none", kind, val, cyc);
        end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.kind != kind || (kind == 0 && e.val != val)) begin
                errors++;
                $display("FAIL event: got kind %0d val %0d at cycle %0d, expected kind %0d val %0d at cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            take(period_valid, 0, int'(period_out));
            take(err_early, 1, 0);
            take(err_missing, 2, 0);
            while (expq.size() > 0 && expq[0].cyc <= cyc) begin
                checks++; errors++;
                $display("FAIL missed_event: got nothing at cycle %0d, expected kind %0d val %0d",
                         cyc, expq[0].kind, expq[0].val);
                void'(expq.pop_front());
            end
            if (exp_locked.exists(cyc)) chk("locked", int'(locked), exp_locked[cyc]);
            if (exp_ec.exists(cyc))     chk("err_count", int'(err_count), exp_ec[cyc]);
        end
    end

    initial begin
        int gap;
        repeat (3) @(posedge clk);
        #1;
        release_reset();

        repeat (6) tick_seq(10, 1);
        @(negedge clk);
        chk("locked_after_clean_run", int'(locked), 1);

        tick_seq(8, 1);
        repeat (5) tick_seq(10, 1);

        tick_seq(30, 1);
        chk("hunting_after_missing", int'(locked), 0);

        tick_seq(9, 1); tick_seq(11, 1); tick_seq(9, 1);
        repeat (3) tick_seq(10, 1);

        repeat (6) tick_seq(10, 5);

        do_reset(1'b1);
        repeat (3) drive_cycle(1'b0);

        for (int i = 0; i < 60; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(7, 12));
            tick_seq(gap, int'($urandom_range(1, gap - 1)));
        end

        do_reset(1'b0);
        repeat (301) tick_seq(8, 1);
        repeat (3) drive_cycle(1'b0);
        @(negedge clk);
`ifdef TICK_PERIOD_MONITOR_ERRCNT_EN
        chk("err_count_saturated", int'(err_count), 255);
`else
        chk("err_count_tied_off", int'(err_count), 0);
`endif

        repeat (15) drive_cycle(1'b0);
        @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
